// File: rtl/operand_reader_pkg.sv
// Shared defaults, address-width derivation and FSM state encoding for operand_reader.
package operand_reader_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int MAX_DIM_DEF    = 4;

  function automatic int calc_aw(input int max_dim);
    return (max_dim > 1) ? $clog2(max_dim) : 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/operand_reader.sv
// Streams a stored operand matrix element by element over a valid/ready port.
// Optional column-major read-out is enabled by defining OPERAND_READER_TRANSPOSE_EN.
module operand_reader
  import operand_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_DIM    = MAX_DIM_DEF,
  localparam int AW        = calc_aw(MAX_DIM)
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          start_i,
  input  logic [AW-1:0]                 n_dim_i,
  input  logic [AW-1:0]                 m_dim_i,
`ifdef OPERAND_READER_TRANSPOSE_EN
  input  logic                          transpose_i,
`endif
  output logic [AW-1:0]                 rd_addr_o,
  input  logic [DATA_WIDTH*MAX_DIM-1:0] row_i,
  output logic [DATA_WIDTH-1:0]         elem_o,
  output logic                          elem_valid_o,
  input  logic                          elem_ready_i,
  output logic                          elem_eol_o,
  output logic                          elem_last_o,
  output logic                          busy_o,
  output logic                          done_o
);

  // Handshake: an element moves on a rising edge where elem_valid_o && elem_ready_i;
  // while elem_valid_o is high and elem_ready_i low, elem_o/eol/last are held.

  state_t          state;
  logic [AW-1:0]   row_cnt;
  logic [AW-1:0]   col_cnt;
  logic [AW-1:0]   n_lat;
  logic [AW-1:0]   m_lat;

  logic [AW-1:0]   lim_n;
  logic [AW-1:0]   lim_m;
  logic            tr_cur;
  logic            row_end;
  logic            col_end;
  logic [AW-1:0]   next_row;
  logic [AW-1:0]   next_col;
  logic            fetch_eol;
  logic            fetch_last;
  logic [DATA_WIDTH-1:0] sel_elem;

`ifdef OPERAND_READER_TRANSPOSE_EN
  logic tr_lat;
  assign tr_cur = (state == ST_IDLE) ? transpose_i : tr_lat;
`else
  assign tr_cur = 1'b0;
`endif

  // Counters hold the position of the next element to load into elem_o, so the
  // memory row for that element is already on rd_addr_o when the load happens.
  assign rd_addr_o = row_cnt;
  assign sel_elem  = row_i[int'(col_cnt)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    lim_n      = (state == ST_IDLE) ? n_dim_i : n_lat;
    lim_m      = (state == ST_IDLE) ? m_dim_i : m_lat;
    row_end    = (row_cnt == lim_n);
    col_end    = (col_cnt == lim_m);
    next_row   = row_cnt;
    next_col   = col_cnt;
    fetch_last = row_end && col_end;
    if (tr_cur) begin
      fetch_eol = row_end;
      if (row_end) begin
        next_row = '0;
        next_col = col_end ? '0 : col_cnt + 1'b1;
      end else begin
        next_row = row_cnt + 1'b1;
      end
    end else begin
      fetch_eol = col_end;
      if (col_end) begin
        next_col = '0;
        next_row = row_end ? '0 : row_cnt + 1'b1;
      end else begin
        next_col = col_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= ST_IDLE;
      row_cnt      <= '0;
      col_cnt      <= '0;
      n_lat        <= '0;
      m_lat        <= '0;
`ifdef OPERAND_READER_TRANSPOSE_EN
      tr_lat       <= 1'b0;
`endif
      elem_o       <= '0;
      elem_valid_o <= 1'b0;
      elem_eol_o   <= 1'b0;
      elem_last_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            n_lat        <= n_dim_i;
            m_lat        <= m_dim_i;
`ifdef OPERAND_READER_TRANSPOSE_EN
            tr_lat       <= transpose_i;
`endif
            elem_o       <= sel_elem;
            elem_eol_o   <= fetch_eol;
            elem_last_o  <= fetch_last;
            elem_valid_o <= 1'b1;
            row_cnt      <= next_row;
            col_cnt      <= next_col;
            busy_o       <= 1'b1;
            state        <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (elem_ready_i) begin
            if (elem_last_o) begin
              elem_valid_o <= 1'b0;
              elem_eol_o   <= 1'b0;
              elem_last_o  <= 1'b0;
              row_cnt      <= '0;
              col_cnt      <= '0;
              done_o       <= 1'b1;
              state        <= ST_DONE;
            end else begin
              elem_o      <= sel_elem;
              elem_eol_o  <= fetch_eol;
              elem_last_o <= fetch_last;
              row_cnt     <= next_row;
              col_cnt     <= next_col;
            end
          end
        end
        ST_DONE: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_reader.sv
// Scoreboard bench for operand_reader: random matrices and ready patterns against a loop-order model.
module tb_operand_reader;

  localparam int DW = 8;
  localparam int MD = 4;
  localparam int AW = 2;
  localparam int EW = DW + 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [AW-1:0]     n_dim = '0;
  logic [AW-1:0]     m_dim = '0;
`ifdef OPERAND_READER_TRANSPOSE_EN
  logic              transpose = 1'b0;
`endif
  logic [AW-1:0]     rd_addr;
  logic [DW*MD-1:0]  row;
  logic [DW-1:0]     elem;
  logic              valid;
  logic              ready = 1'b1;
  logic              eol;
  logic              last;
  logic              busy;
  logic              done;

  logic [DW*MD-1:0]  mem [MD];
  logic [EW-1:0]     exp_q[$];
  int                checks = 0;
  int                errors = 0;
  int                popped = 0;
  int                ready_mode = 0;
  bit                done_pending = 1'b0;

  always #5 clk = ~clk;

  assign row = mem[rd_addr];

  operand_reader dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .n_dim_i      (n_dim),
    .m_dim_i      (m_dim),
`ifdef OPERAND_READER_TRANSPOSE_EN
    .transpose_i  (transpose),
`endif
    .rd_addr_o    (rd_addr),
    .row_i        (row),
    .elem_o       (elem),
    .elem_valid_o (valid),
    .elem_ready_i (ready),
    .elem_eol_o   (eol),
    .elem_last_o  (last),
    .busy_o       (busy),
    .done_o       (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference order: outer loop over lines, inner loop over elements of a line.
  task automatic push_model(input int n, input int m, input bit tr);
    int outer;
    int inner;
    outer = tr ? m : n;
    inner = tr ? n : m;
    for (int o = 0; o <= outer; o++) begin
      for (int i = 0; i <= inner; i++) begin
        int r;
        int c;
        logic [DW*MD-1:0] rw;
        logic [DW-1:0] e;
        r = tr ? i : o;
        c = tr ? o : i;
        rw = mem[r];
        e = rw[c*DW +: DW];
        exp_q.push_back({e, (i == inner), (i == inner) && (o == outer)});
      end
    end
  endtask

  task automatic do_start(input int n, input int m, input bit tr, input bit push);
    @(posedge clk);
    #1;
    n_dim = AW'(n);
    m_dim = AW'(m);
`ifdef OPERAND_READER_TRANSPOSE_EN
    transpose = tr;
`endif
    start = 1'b1;
    if (push) push_model(n, m, tr);
    @(posedge clk);
    #1;
    start = 1'b0;
    n_dim = AW'($urandom_range(0, MD - 1));
    m_dim = AW'($urandom_range(0, MD - 1));
`ifdef OPERAND_READER_TRANSPOSE_EN
    transpose = 1'($urandom_range(0, 1));
`endif
  endtask

  task automatic wait_done(input int exp_cyc);
    int cyc;
    cyc = 0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (done) break;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done after %0d cycles, %0d elements outstanding", cyc, exp_q.size());
      exp_q.delete();
      done_pending = 1'b0;
    end else if (exp_cyc >= 0) begin
      check("latency", 64'(cyc), 64'(exp_cyc));
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {rd_addr, elem, valid, eol, last, busy, done}, '0);
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       ready = 1'b1;
      1:       ready = ~ready;
      default: ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compares every presented element with the queue head, pops on transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      check_outputs_zero("reset_outputs");
    end else begin
      if (done_pending) begin
        check("done_pulse", {done, valid}, 2'b10);
        done_pending = 1'b0;
      end else begin
        check("done_quiet", done, 1'b0);
      end
      if (valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_elem: got elem %0h eol %0b last %0b with nothing expected", elem, eol, last);
        end else begin
          logic [EW-1:0] head;
          head = exp_q[0];
          check("elem", {elem, eol, last}, head);
          if (ready) begin
            void'(exp_q.pop_front());
            popped++;
            if (head[0]) done_pending = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int base;
    int cnt;
    int n;
    int m;
    bit tr;
    for (int i = 0; i < MD; i++) mem[i] = '0;

    #1 rst_n = 1'b0;
    #1 check_outputs_zero("reset_state");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", {busy, valid, done}, 3'b000);

    // 2x4 matrix at full rate
    mem[0] = 32'h04030201;
    mem[1] = 32'h08070605;
    ready_mode = 0;
    do_start(1, 3, 1'b0, 1'b1);
    wait_done(9);

    // same matrix under toggling ready
    ready_mode = 1;
    do_start(1, 3, 1'b0, 1'b1);
    wait_done(-1);

    // 1x1 matrix
    ready_mode = 0;
    mem[0] = 32'h000000AA;
    do_start(0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_1x1", busy, (i < 2) ? 1'b1 : 1'b0);
    end

    // second start while streaming must be ignored
    mem[0] = 32'h04030201;
    mem[1] = 32'h08070605;
    ready_mode = 2;
    do_start(1, 3, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    n_dim = '0;
    m_dim = '0;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(-1);

    // asynchronous reset after the third element
    ready_mode = 0;
    base = popped;
    do_start(1, 3, 1'b0, 1'b1);
    cnt = 0;
    while (popped < base + 3 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("reset_reach_3rd", 64'(popped - base >= 3), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    done_pending = 1'b0;
    #1 check_outputs_zero("async_reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("quiet_after_reset", {busy, valid, done}, 3'b000);
    do_start(1, 3, 1'b0, 1'b1);
    wait_done(9);

`ifdef OPERAND_READER_TRANSPOSE_EN
    // column-major 2x2
    mem[0] = 32'h00000201;
    mem[1] = 32'h00000403;
    ready_mode = 0;
    do_start(1, 1, 1'b1, 1'b1);
    wait_done(5);
`endif

    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < MD; i++) mem[i] = $urandom;
      n = $urandom_range(0, MD - 1);
      m = $urandom_range(0, MD - 1);
`ifdef OPERAND_READER_TRANSPOSE_EN
      tr = 1'($urandom_range(0, 1));
`else
      tr = 1'b0;
`endif
      ready_mode = $urandom_range(0, 2);
      do_start(n, m, tr, 1'b1);
      wait_done((ready_mode == 0) ? (n + 1) * (m + 1) + 1 : -1);
    end

    repeat (2) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
